hazard_ctrl_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
//  - Forwards to E from M or W.
//  - Stalls on load-use for a configurable memory latency.
//  - Holds F/D/E during multicycle execute ops (mul/div) via a small FSM.
//  - Flushes on taken branch/jump; counts stall cycles for perf.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/fwd_select.sv | 27 ++
 rtl/hazard_ctrl_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned REG_ZERO = 0;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding mux select for the E stage; the M result takes priority over W.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic              reg_write_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              reg_write_w_i,
    output logic [1:0]        fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (FWD_EN && (rs_i != REG_AW'(REG_ZERO))) begin
            if (reg_write_m_i && (rs_i == rd_m_i)) begin
                fwd_o = FWD_MEM;
            end else if (reg_write_w_i && (rs_i == rd_w_i)) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the F/D/E/M/W pipeline: forwarding selects, load-use stall
// counter, multicycle-execute hold FSM, branch flush and a stall-cycle perf counter.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MC_LAT   = 4,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              McStartE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              McBusy,
    output logic [PERF_W-1:0] StallCycles
);

    localparam int unsigned LU_W = $clog2(LOAD_LAT + 1);
    localparam int unsigned MC_W = $clog2(MC_LAT);
    localparam logic [LU_W-1:0] LU_RELOAD = LU_W'(LOAD_LAT - 1);
    localparam logic [MC_W-1:0] MC_RELOAD = MC_W'(MC_LAT - 2);

    logic [1:0] fwd_a, fwd_b;

    fwd_select #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
        .rs_i(Rs1E), .rd_m_i(RdM), .reg_write_m_i(RegWriteM),
        .rd_w_i(RdW), .reg_write_w_i(RegWriteW), .fwd_o(fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
        .rs_i(Rs2E), .rd_m_i(RdM), .reg_write_m_i(RegWriteM),
        .rd_w_i(RdW), .reg_write_w_i(RegWriteW), .fwd_o(fwd_b)
    );

    logic hit_e, hit_m, hit_w, lu_det;

    assign hit_e  = RegWriteE && (RdE != REG_AW'(REG_ZERO)) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign hit_m  = RegWriteM && (RdM != REG_AW'(REG_ZERO)) && ((RdM == Rs1D) || (RdM == Rs2D));
    assign hit_w  = RegWriteW && (RdW != REG_AW'(REG_ZERO)) && ((RdW == Rs1D) || (RdW == Rs2D));
    assign lu_det = FWD_EN ? (ResultSrcE0 && hit_e) : (hit_e || hit_m || hit_w);

    mc_state_e        mc_state_q, mc_state_d;
    logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic             mc_busy;

    // The final BUSY cycle (count exhausted) is the op's last E cycle, so it is not busy.
    always_comb begin
        mc_state_d = mc_state_q;
        mc_cnt_d   = mc_cnt_q;
        mc_busy    = 1'b0;
        case (mc_state_q)
            MC_IDLE: begin
                if (McStartE) begin
                    mc_busy    = 1'b1;
                    mc_state_d = MC_BUSY;
                    mc_cnt_d   = MC_RELOAD;
                end
            end
            MC_BUSY: begin
                if (mc_cnt_q != '0) begin
                    mc_busy  = 1'b1;
                    mc_cnt_d = mc_cnt_q - 1'b1;
                end else begin
                    mc_state_d = MC_IDLE;
                end
            end
            default: mc_state_d = MC_IDLE;
        endcase
    end

    logic [LU_W-1:0] lu_cnt_q, lu_cnt_d;
    logic            lu_active, lu_trig, lu_stall, branch;

    assign lu_active = (lu_cnt_q != '0);
    assign lu_trig   = lu_det && !PCSrcE;
    assign lu_stall  = !mc_busy && (lu_trig || lu_active);
    assign branch    = PCSrcE && !mc_busy;

    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (lu_active) begin
            lu_cnt_d = lu_cnt_q - 1'b1;
        end else if (lu_trig && !mc_busy) begin
            lu_cnt_d = LU_RELOAD;
        end
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushM    = 1'b1;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        McBusy    = 1'b0;
        if (!rst) begin
            StallF    = mc_busy || lu_stall;
            StallD    = mc_busy || lu_stall;
            StallE    = mc_busy;
            FlushD    = branch;
            FlushE    = branch || lu_stall;
            FlushM    = mc_busy;
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            McBusy    = mc_busy;
        end
    end

    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    assign stall_cycles_d = stall_cycles_q + PERF_W'(StallF);
    assign StallCycles    = stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_state_q     <= MC_IDLE;
            mc_cnt_q       <= '0;
            lu_cnt_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            mc_state_q     <= mc_state_d;
            mc_cnt_q       <= mc_cnt_d;
            lu_cnt_q       <= lu_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized check of two hazard_ctrl_unit configurations against a cycle-level reference model.
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McStartE;

    logic        stall_f [2], stall_d [2], stall_e [2];
    logic        flush_d [2], flush_e [2], flush_m [2];
    logic [1:0]  fwd_a [2], fwd_b [2];
    logic        mc_busy [2];
    logic [31:0] perf_o [2];

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(2), .MC_LAT(4), .FWD_EN(1'b1), .PERF_W(32)) u_dut_fwd (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .McStartE(McStartE),
        .StallF(stall_f[0]), .StallD(stall_d[0]), .StallE(stall_e[0]),
        .FlushD(flush_d[0]), .FlushE(flush_e[0]), .FlushM(flush_m[0]),
        .ForwardAE(fwd_a[0]), .ForwardBE(fwd_b[0]), .McBusy(mc_busy[0]), .StallCycles(perf_o[0])
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .MC_LAT(2), .FWD_EN(1'b0), .PERF_W(32)) u_dut_nofwd (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .McStartE(McStartE),
        .StallF(stall_f[1]), .StallD(stall_d[1]), .StallE(stall_e[1]),
        .FlushD(flush_d[1]), .FlushE(flush_e[1]), .FlushM(flush_m[1]),
        .ForwardAE(fwd_a[1]), .ForwardBE(fwd_b[1]), .McBusy(mc_busy[1]), .StallCycles(perf_o[1])
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwe, rwm, rww, lde, pcsrc, mcs, rst;
    } stim_t;

    // Model state: E cycles already spent by the running multicycle op, load-use stall
    // cycles still owed, and the stall-cycle tally.
    int          mc_e [2], mc_e_n [2];
    int          owed [2], owed_n [2];
    logic [31:0] perf_m [2], perf_n [2];

    function automatic int cfg_load_lat(int i); return (i == 0) ? 2 : 3; endfunction
    function automatic int cfg_mc_lat(int i);   return (i == 0) ? 4 : 2; endfunction
    function automatic bit cfg_fwd(int i);      return (i == 0); endfunction

    function automatic bit hit(logic we, logic [4:0] rd, logic [4:0] a, logic [4:0] b);
        return we && (rd != 0) && ((rd == a) || (rd == b));
    endfunction

    function automatic logic [1:0] fwd_model(bit en, logic [4:0] rs, stim_t s);
        if (!en || rs == 0) return 2'd0;
        if (s.rwm && rs == s.rdm) return 2'd2;
        if (s.rww && rs == s.rdw) return 2'd1;
        return 2'd0;
    endfunction

    function automatic stim_t quiet();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic eval_check(input int i, input stim_t s);
        bit busy, det, trig, lustall, sf, fd, fe;
        int cur;
        if (s.rst) begin
            chk($sformatf("StallF[%0d]", i), 64'(stall_f[i]), 64'd0);
            chk($sformatf("StallD[%0d]", i), 64'(stall_d[i]), 64'd0);
            chk($sformatf("StallE[%0d]", i), 64'(stall_e[i]), 64'd0);
            chk($sformatf("FlushD[%0d]", i), 64'(flush_d[i]), 64'd1);
            chk($sformatf("FlushE[%0d]", i), 64'(flush_e[i]), 64'd1);
            chk($sformatf("FlushM[%0d]", i), 64'(flush_m[i]), 64'd1);
            chk($sformatf("FwdA[%0d]", i), 64'(fwd_a[i]), 64'd0);
            chk($sformatf("FwdB[%0d]", i), 64'(fwd_b[i]), 64'd0);
            chk($sformatf("McBusy[%0d]", i), 64'(mc_busy[i]), 64'd0);
            chk($sformatf("Perf[%0d]", i), 64'(perf_o[i]), 64'(perf_m[i]));
            mc_e_n[i] = 0;
            owed_n[i] = 0;
            perf_n[i] = '0;
            return;
        end
        if (mc_e[i] == 0) begin
            busy      = s.mcs;
            mc_e_n[i] = s.mcs ? 1 : 0;
        end else begin
            cur       = mc_e[i] + 1;
            busy      = (cur < cfg_mc_lat(i));
            mc_e_n[i] = (cur == cfg_mc_lat(i)) ? 0 : cur;
        end
        if (cfg_fwd(i))
            det = s.lde && hit(s.rwe, s.rde, s.rs1d, s.rs2d);
        else
            det = hit(s.rwe, s.rde, s.rs1d, s.rs2d) || hit(s.rwm, s.rdm, s.rs1d, s.rs2d) ||
                  hit(s.rww, s.rdw, s.rs1d, s.rs2d);
        trig      = det && !s.pcsrc;
        lustall   = !busy && (owed[i] > 0 || trig);
        owed_n[i] = (owed[i] > 0) ? owed[i] - 1 : ((trig && !busy) ? cfg_load_lat(i) - 1 : 0);
        sf = busy || lustall;
        fd = s.pcsrc && !busy;
        fe = fd || lustall;
        chk($sformatf("StallF[%0d]", i), 64'(stall_f[i]), 64'(sf));
        chk($sformatf("StallD[%0d]", i), 64'(stall_d[i]), 64'(sf));
        chk($sformatf("StallE[%0d]", i), 64'(stall_e[i]), 64'(busy));
        chk($sformatf("FlushD[%0d]", i), 64'(flush_d[i]), 64'(fd));
        chk($sformatf("FlushE[%0d]", i), 64'(flush_e[i]), 64'(fe));
        chk($sformatf("FlushM[%0d]", i), 64'(flush_m[i]), 64'(busy));
        chk($sformatf("FwdA[%0d]", i), 64'(fwd_a[i]), 64'(fwd_model(cfg_fwd(i), s.rs1e, s)));
        chk($sformatf("FwdB[%0d]", i), 64'(fwd_b[i]), 64'(fwd_model(cfg_fwd(i), s.rs2e, s)));
        chk($sformatf("McBusy[%0d]", i), 64'(mc_busy[i]), 64'(busy));
        chk($sformatf("Perf[%0d]", i), 64'(perf_o[i]), 64'(perf_m[i]));
        perf_n[i] = perf_m[i] + (sf ? 32'd1 : 32'd0);
    endtask

    task automatic cycle(input stim_t s);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            mc_e[i]   = mc_e_n[i];
            owed[i]   = owed_n[i];
            perf_m[i] = perf_n[i];
        end
        rst = s.rst;
        Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
        RdE = s.rde; RdM = s.rdm; RdW = s.rdw;
        RegWriteE = s.rwe; RegWriteM = s.rwm; RegWriteW = s.rww;
        ResultSrcE0 = s.lde; PCSrcE = s.pcsrc; McStartE = s.mcs;
        @(negedge clk);
        for (int i = 0; i < 2; i++) eval_check(i, s);
    endtask

    task automatic reset_cycle();
        stim_t s;
        s = quiet();
        s.rst = 1'b1;
        cycle(s);
    endtask

    initial begin
        stim_t s;
        rst = 1'b1;
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McStartE} = '0;
        for (int i = 0; i < 2; i++) begin
            mc_e_n[i] = 0; owed_n[i] = 0; perf_n[i] = '0;
        end
        repeat (2) @(posedge clk);
        reset_cycle();

        // Forwarding priority and x0 exclusion
        s = quiet();
        s.rs1e = 5'd5; s.rdm = 5'd5; s.rwm = 1'b1; s.rdw = 5'd5; s.rww = 1'b1;
        cycle(s);
        chk("fwd_m_over_w", 64'(fwd_a[0]), 64'd2);
        chk("fwd_off_nofwd", 64'(fwd_a[1]), 64'd0);
        s.rs1e = 5'd0; s.rdm = 5'd0; s.rdw = 5'd0;
        cycle(s);
        chk("fwd_x0", 64'(fwd_a[0]), 64'd0);

        // Load-use with two stall cycles
        reset_cycle();
        s = quiet();
        s.lde = 1'b1; s.rde = 5'd7; s.rwe = 1'b1; s.rs2d = 5'd7;
        cycle(s);
        chk("lu_stall_c0", 64'(stall_f[0]), 64'd1);
        chk("lu_flushe_c0", 64'(flush_e[0]), 64'd1);
        cycle(quiet());
        chk("lu_stall_c1", 64'(stall_d[0]), 64'd1);
        cycle(quiet());
        chk("lu_release", 64'(stall_f[0]), 64'd0);
        chk("lu_perf", 64'(perf_o[0]), 64'd2);

        // Branch resolved alongside load-use: redirect wins, no stall armed
        reset_cycle();
        s.pcsrc = 1'b1;
        cycle(s);
        chk("br_flushd", 64'(flush_d[0]), 64'd1);
        chk("br_flushe", 64'(flush_e[0]), 64'd1);
        chk("br_nostall", 64'(stall_f[0]), 64'd0);
        cycle(quiet());
        chk("br_no_lu_after", 64'(stall_f[0]), 64'd0);

        // Multicycle op holds E for MC_LAT-1 cycles and masks a branch
        reset_cycle();
        s = quiet(); s.mcs = 1'b1;
        cycle(s);
        chk("mc_c0_stalle", 64'(stall_e[0]), 64'd1);
        s = quiet(); s.pcsrc = 1'b1;
        cycle(s);
        chk("mc_br_masked", 64'(flush_d[0]), 64'd0);
        chk("mc_c1_flushm", 64'(flush_m[0]), 64'd1);
        cycle(quiet());
        chk("mc_c2_stallf", 64'(stall_f[0]), 64'd1);
        cycle(quiet());
        chk("mc_release", 64'(mc_busy[0]), 64'd0);
        chk("mc_release_se", 64'(stall_e[0]), 64'd0);

        // No-forwarding configuration stalls on a RAW against M
        reset_cycle();
        s = quiet(); s.rdm = 5'd3; s.rwm = 1'b1; s.rs1d = 5'd3; s.rs1e = 5'd3;
        cycle(s);
        chk("nofwd_stall", 64'(stall_f[1]), 64'd1);
        chk("nofwd_fwd", 64'(fwd_a[1]), 64'd0);

        // Reset in the middle of a multicycle op aborts it
        reset_cycle();
        s = quiet(); s.mcs = 1'b1;
        cycle(s);
        reset_cycle();
        cycle(quiet());
        chk("rst_abort_busy", 64'(mc_busy[0]), 64'd0);
        chk("rst_abort_stall", 64'(stall_f[0]), 64'd0);
        chk("rst_abort_perf", 64'(perf_o[0]), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            s.rs1d  = 5'($urandom_range(0, 3));
            s.rs2d  = 5'($urandom_range(0, 3));
            s.rs1e  = 5'($urandom_range(0, 3));
            s.rs2e  = 5'($urandom_range(0, 3));
            s.rde   = 5'($urandom_range(0, 3));
            s.rdm   = 5'($urandom_range(0, 3));
            s.rdw   = 5'($urandom_range(0, 3));
            s.rwe   = 1'($urandom_range(0, 1));
            s.rwm   = 1'($urandom_range(0, 1));
            s.rww   = 1'($urandom_range(0, 1));
            s.lde   = ($urandom_range(0, 2) == 0);
            s.pcsrc = ($urandom_range(0, 7) == 0);
            s.mcs   = ($urandom_range(0, 9) == 0);
            s.rst   = ($urandom_range(0, 63) == 0);
            cycle(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
